z8_stack_unit: RTL and testbench
================================

# z8_stack_unit

Parametrised hardware stack engine for the z8 core. It replaces the fixed 16-entry stack region (0xF0–0xFF) held in data memory with a dedicated LIFO that has configurable width and depth. It also adds behaviour the memory-mapped stack does not have: a simultaneous push/pop replace, a flush, sticky overflow and underflow error flags, and a memory-map-compatible stack pointer. It sits beside the register file. The EXECUTE stage drives PSHR/PSHD/POP through it, and WRITEBACK reads `top_data`.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 16, number of entries; must be ≥ 2.
- `STACK_BASE`, 8'hFF, address reported by `sp_addr` when the stack is empty.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `push`  in  1  push request, sampled on the rising edge.
- `pop`  in  1  pop request, sampled on the rising edge.
- `push_data`  in  WIDTH  value to push.
- `flush`  in  1  empties the stack.
- `clr_err`  in  1  clears the sticky error flags.
- `top_data`  out  WIDTH  registered copy of the current top entry; 0 when empty.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky flag: a push was dropped.
- `underflow`  out  1  sticky flag: a pop was attempted on an empty stack.
- `sp_addr`  out  8  next free address, equal to `STACK_BASE - count` (8-bit wrap).

## Operation
Reset values while `rst_n` is low:
- `count = 0`, `top_data = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `underflow = 0`, `sp_addr = STACK_BASE`.
- Storage array contents are don't-care.

Per-edge priority, highest first:
1. `flush`: `count ← 0`, `top_data ← 0`. Any `push`/`pop` in the same cycle is ignored and produces no error. Sticky flags are unaffected.
2. `push && pop && !empty` (replace): writes entry `count-1` with `push_data`; `top_data ← push_data`; `count` is unchanged. This is legal when full and sets no flag.
3. `push && pop && empty`: the pop is rejected and `underflow ← 1`. The push proceeds as case 4.
4. `push` only:
   - If not full: write entry `count`, `count ← count+1`, `top_data ← push_data`.
   - If full: no state change, `overflow ← 1`.
5. `pop` only:
   - If not empty: `count ← count-1`, `top_data ← entry[count-2]`, or 0 when the new count is 0.
   - If empty: no state change, `underflow ← 1`.

Other rules:
- `clr_err` clears both sticky flags. If a new error occurs in the same cycle, the set wins and the flag reads 1.
- `full`, `empty` and `sp_addr` are combinational decodes of `count` only.
- `sp_addr` arithmetic is 8-bit modulo. It uses `STACK_BASE - count` zero-extended. With the defaults, full gives `sp_addr = 8'hEF`.
- Popped values are observed on `top_data` before asserting `pop`; there is no separate pop-data port.

## Timing
- Every request takes effect on the edge where it is sampled. `top_data`, `count` and the flags show the result one cycle later (zero-cycle request-to-edge, visible after that edge).
- There is no back-pressure. Requests are never stalled, only dropped and flagged.
- Back-to-back pushes and pops are sustained at one per cycle.
- `top_data` never reads stale data: after any push, pop or replace it equals the new top on the following cycle.
- If `rst_n` asserts mid-sequence, it clears immediately without waiting for `clk`. The first request after deassertion is processed normally on the next rising edge.
- Inputs are assumed synchronous to `clk`. `rst_n` deassertion is synchronised externally.

## Test plan
- Reset: drive `rst_n = 0` mid-clock -> `count = 0`, `empty = 1`, `top_data = 0`, `sp_addr = 8'hFF` immediately, with no clock edge needed.
- Fill and overflow: push 0xA0..0xAF (16 cycles) -> `full = 1`, `top_data = 0xAF`, `sp_addr = 8'hEF`. A 17th push of 0x55 -> `count` stays 16, `top_data = 0xAF`, `overflow = 1`.
- LIFO drain and underflow: from full, pop 16 times -> `top_data` reads 0xAE, 0xAD, …, 0xA0, then 0. A 17th pop -> `underflow = 1`, `count = 0`.
- Replace: push 0x11, then 0x22; then push 0x33 with pop -> `count = 2`, `top_data = 0x33`; pop -> `top_data = 0x11`. Replace when full -> no flag.
- Empty push+pop, flush priority and clear: on empty, push 0x7E with pop -> `count = 1`, `top_data = 0x7E`, `underflow = 1`. Then flush with push in the same cycle -> `count = 0`, `underflow` still 1. `clr_err` plus a pop on empty in the same cycle -> `underflow` stays 1. `clr_err` alone -> 0.
- Parameter sweep: `WIDTH = 16`, `DEPTH = 4`, `STACK_BASE = 8'h80` -> full after 4 pushes, `sp_addr = 8'h7C`, 16-bit values are preserved across push/pop.

Source files
------------

// File: rtl/z8_stack_unit.sv
// z8_stack_unit: parametrised LIFO stack engine for the z8 core.
// Holds up to DEPTH words of WIDTH bits. It supports push, pop, a push+pop
// replace of the top entry, and flush. It keeps sticky overflow/underflow
// flags and reports a memory-map-compatible stack pointer.
module z8_stack_unit #(
  parameter int         WIDTH      = 8,
  parameter int         DEPTH      = 16,
  parameter logic [7:0] STACK_BASE = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow,
  output logic [7:0]                 sp_addr
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  // Storage is never reset; only entries below count are ever read.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             do_replace;
  logic             do_push;
  logic             do_pop;
  logic             set_ovf;
  logic             set_udf;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] below_top;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign sp_addr = STACK_BASE - 8'(count);

  // Decode the request into one action, with flush taking priority over everything else.
  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    if (!flush) begin
      do_replace = push && pop && !empty;
      // A pop paired with a push on an empty stack is rejected; the push still goes ahead.
      do_push    = push && !do_replace && !full;
      set_ovf    = push && !do_replace && full;
      do_pop     = pop && !push && !empty;
      set_udf    = pop && empty;
    end
    wr_idx    = do_replace ? AW'(count - CW'(1)) : AW'(count);
    rd_idx    = AW'(count - CW'(2));
    // The entry that becomes the new top after a pop. When count is 1, popping empties the stack.
    below_top = (count == CW'(1)) ? '0 : mem[rd_idx];
  end

  // Write the pushed or replaced word into the array.
  always_ff @(posedge clk) begin
    if (do_replace || do_push) mem[wr_idx] <= push_data;
  end

  // Update count and the registered top-of-stack copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      top_data <= '0;
    end else if (flush) begin
      count    <= '0;
      top_data <= '0;
    end else if (do_replace) begin
      top_data <= push_data;
    end else if (do_push) begin
      count    <= count + CW'(1);
      top_data <= push_data;
    end else if (do_pop) begin
      count    <= count - CW'(1);
      top_data <= below_top;
    end
  end

  // Update the sticky error flags. A new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !clr_err) || set_ovf;
      underflow <= (underflow && !clr_err) || set_udf;
    end
  end

endmodule

// File: tb/tb_z8_stack_unit.sv
// Testbench for z8_stack_unit. It runs a default instance (8x16, base FF) and a
// swept instance (16x4, base 80). A queue-free array model of each stack is
// checked against the DUT outputs every cycle, with directed literal checks on top.
module tb_z8_stack_unit;

  localparam int         DEPTH_B = 4;
  localparam logic [7:0] BASE_B  = 8'h80;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic       push_a = 0, pop_a = 0, flush_a = 0, clr_a = 0;
  logic [7:0] data_a = 0;
  logic [7:0] top_a, sp_a;
  logic [4:0] count_a;
  logic       full_a, empty_a, ovf_a, udf_a;

  logic        push_b = 0, pop_b = 0, flush_b = 0, clr_b = 0;
  logic [15:0] data_b = 0;
  logic [15:0] top_b;
  logic [7:0]  sp_b;
  logic [2:0]  count_b;
  logic        full_b, empty_b, ovf_b, udf_b;

  int compared   = 0;
  int mismatched = 0;

  z8_stack_unit dut_a (
    .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .push_data(data_a),
    .flush(flush_a), .clr_err(clr_a), .top_data(top_a), .count(count_a),
    .full(full_a), .empty(empty_a), .overflow(ovf_a), .underflow(udf_a), .sp_addr(sp_a)
  );

  z8_stack_unit #(.WIDTH(16), .DEPTH(DEPTH_B), .STACK_BASE(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .push_data(data_b),
    .flush(flush_b), .clr_err(clr_b), .top_data(top_b), .count(count_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b), .underflow(udf_b), .sp_addr(sp_b)
  );

  always #5 clk = ~clk;

  // Reference model: one stack per instance, held as an array plus an occupancy.
  logic [15:0] st   [2][16];
  int          mcnt [2] = '{0, 0};
  bit          movf [2] = '{0, 0};
  bit          mudf [2] = '{0, 0};
  int          mdep [2] = '{16, DEPTH_B};
  logic [7:0]  mbase[2] = '{8'hFF, BASE_B};

  task automatic model_step(input int k, input logic p, input logic po, input logic [15:0] d,
                            input logic f, input logic c);
    bit o, u;
    o = c ? 1'b0 : movf[k];
    u = c ? 1'b0 : mudf[k];
    if (f) begin
      mcnt[k] = 0;
    end else if (p && po && mcnt[k] > 0) begin
      st[k][mcnt[k]-1] = d;
    end else begin
      if (po && mcnt[k] == 0) u = 1'b1;
      if (p) begin
        if (mcnt[k] < mdep[k]) begin
          st[k][mcnt[k]] = d;
          mcnt[k]++;
        end else begin
          o = 1'b1;
        end
      end else if (po && mcnt[k] > 0) begin
        mcnt[k]--;
      end
    end
    movf[k] = o;
    mudf[k] = u;
  endtask

  function automatic logic [15:0] exp_top(input int k);
    return (mcnt[k] > 0) ? st[k][mcnt[k]-1] : 16'h0;
  endfunction

  function automatic logic [7:0] exp_sp(input int k);
    logic [7:0] c8;
    c8 = 8'(mcnt[k]);
    return mbase[k] - c8;
  endfunction

  always @(negedge rst_n) begin
    mcnt = '{0, 0};
    movf = '{0, 0};
    mudf = '{0, 0};
  end

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, push_a, pop_a, {8'h00, data_a}, flush_a, clr_a);
      model_step(1, push_b, pop_b, data_b, flush_b, clr_b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the inactive edge.
  always @(negedge clk) begin
    chk("a.count", 32'(count_a), 32'(mcnt[0]));
    chk("a.top",   32'(top_a),   32'(exp_top(0)));
    chk("a.full",  32'(full_a),  32'(mcnt[0] == 16));
    chk("a.empty", 32'(empty_a), 32'(mcnt[0] == 0));
    chk("a.ovf",   32'(ovf_a),   32'(movf[0]));
    chk("a.udf",   32'(udf_a),   32'(mudf[0]));
    chk("a.sp",    32'(sp_a),    32'(exp_sp(0)));
    chk("b.count", 32'(count_b), 32'(mcnt[1]));
    chk("b.top",   32'(top_b),   32'(exp_top(1)));
    chk("b.full",  32'(full_b),  32'(mcnt[1] == DEPTH_B));
    chk("b.empty", 32'(empty_b), 32'(mcnt[1] == 0));
    chk("b.ovf",   32'(ovf_b),   32'(movf[1]));
    chk("b.udf",   32'(udf_b),   32'(mudf[1]));
    chk("b.sp",    32'(sp_b),    32'(exp_sp(1)));
  end

  task automatic step(input logic pa, input logic poa, input logic [7:0] da, input logic fa,
                      input logic ca, input logic pb, input logic pob, input logic [15:0] db,
                      input logic fb, input logic cb);
    @(negedge clk);
    #1;
    push_a = pa; pop_a = poa; data_a = da; flush_a = fa; clr_a = ca;
    push_b = pb; pop_b = pob; data_b = db; flush_b = fb; clr_b = cb;
    @(posedge clk);
    #1;
    push_a = 0; pop_a = 0; flush_a = 0; clr_a = 0;
    push_b = 0; pop_b = 0; flush_b = 0; clr_b = 0;
  endtask

  task automatic sa(input logic p, input logic po, input logic [7:0] d, input logic f, input logic c);
    step(p, po, d, f, c, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic sb(input logic p, input logic po, input logic [15:0] d);
    step(0, 0, 8'h0, 0, 0, p, po, d, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    #23 rst_n = 1;
    chk("reset.count", 32'(count_a), 32'h0);
    chk("reset.sp",    32'(sp_a),    32'hFF);

    // Async reset mid-sequence clears without a clock edge
    sa(1, 0, 8'h12, 0, 0);
    sa(1, 0, 8'h34, 0, 0);
    chk("pre_rst.count", 32'(count_a), 32'd2);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst.count", 32'(count_a), 32'h0);
    chk("arst.empty", 32'(empty_a), 32'h1);
    chk("arst.top",   32'(top_a),   32'h0);
    chk("arst.sp",    32'(sp_a),    32'hFF);
    @(negedge clk);
    #1 rst_n = 1;

    // Fill and overflow
    for (int i = 0; i < 16; i++) sa(1, 0, 8'hA0 + 8'(i), 0, 0);
    chk("fill.full", 32'(full_a), 32'h1);
    chk("fill.top",  32'(top_a),  32'hAF);
    chk("fill.sp",   32'(sp_a),   32'hEF);
    sa(1, 0, 8'h55, 0, 0);
    chk("ovf.count", 32'(count_a), 32'd16);
    chk("ovf.top",   32'(top_a),   32'hAF);
    chk("ovf.flag",  32'(ovf_a),   32'h1);

    // LIFO drain and underflow
    for (int i = 1; i <= 16; i++) begin
      sa(0, 1, 8'h0, 0, 0);
      chk("drain.top", 32'(top_a), (i < 16) ? 32'hAF - 32'(i) : 32'h0);
    end
    sa(0, 1, 8'h0, 0, 0);
    chk("udf.flag",  32'(udf_a),   32'h1);
    chk("udf.count", 32'(count_a), 32'h0);

    // Replace
    sa(0, 0, 8'h0, 0, 1);
    sa(1, 0, 8'h11, 0, 0);
    sa(1, 0, 8'h22, 0, 0);
    sa(1, 1, 8'h33, 0, 0);
    chk("rep.count", 32'(count_a), 32'd2);
    chk("rep.top",   32'(top_a),   32'h33);
    sa(0, 1, 8'h0, 0, 0);
    chk("rep.pop_top", 32'(top_a), 32'h11);
    for (int i = 0; i < 15; i++) sa(1, 0, 8'(i), 0, 0);
    sa(1, 1, 8'h99, 0, 0);
    chk("repfull.count", 32'(count_a), 32'd16);
    chk("repfull.top",   32'(top_a),   32'h99);
    chk("repfull.flags", {30'h0, ovf_a, udf_a}, 32'h0);
    sa(0, 0, 8'h0, 1, 0);

    // Empty push+pop, flush priority, clear
    sa(1, 1, 8'h7E, 0, 0);
    chk("epp.count", 32'(count_a), 32'd1);
    chk("epp.top",   32'(top_a),   32'h7E);
    chk("epp.udf",   32'(udf_a),   32'h1);
    sa(1, 0, 8'h44, 1, 0);
    chk("flush.count", 32'(count_a), 32'd0);
    chk("flush.udf",   32'(udf_a),   32'h1);
    sa(0, 1, 8'h0, 0, 1);
    chk("clr_set.udf", 32'(udf_a), 32'h1);
    sa(0, 0, 8'h0, 0, 1);
    chk("clr.udf", 32'(udf_a), 32'h0);

    // Parameter sweep instance
    for (int i = 0; i < 4; i++) sb(1, 0, 16'hBEE0 + 16'(i * 16'h1111));
    chk("sweep.full", 32'(full_b), 32'h1);
    chk("sweep.sp",   32'(sp_b),   32'h7C);
    chk("sweep.top",  32'(top_b),  32'hF213);
    sb(1, 0, 16'h1234);
    chk("sweep.ovf", 32'(ovf_b), 32'h1);
    sb(0, 1, 16'h0);
    chk("sweep.pop1", 32'(top_b), 32'hE102);
    sb(0, 1, 16'h0);
    chk("sweep.pop2", 32'(top_b), 32'hCFF1);

    // Randomised traffic on both instances
    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = ((i / 97) % 2 == 1) ? 80 : 35;
      if (i == 1000) begin
        @(posedge clk);
        #2 rst_n = 0;
        #4 rst_n = 1;
      end
      step($urandom_range(99) < bias, $urandom_range(99) < 60 - bias / 2 + 20, 8'($urandom),
           $urandom_range(40) == 0, $urandom_range(15) == 0,
           $urandom_range(99) < bias, $urandom_range(99) < 60 - bias / 2 + 20, 16'($urandom),
           $urandom_range(40) == 0, $urandom_range(15) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
